// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request, data-memory and result signals of the load/store unit
interface load_store_unit_if;
    logic        start;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic [31:0] load_data;
    logic        done;
    logic        busy;
    logic        err;
    logic [1:0]  err_code;

    modport master (
        input  start, mem_read, mem_write, funct3, addr, store_data, dmem_rdata, dmem_ack,
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, load_data, done, busy, err, err_code
    );

    modport slave (
        output start, mem_read, mem_write, funct3, addr, store_data, dmem_rdata, dmem_ack,
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, load_data, done, busy, err, err_code
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit: request checking, data memory access with timeout, load formatting
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, FINISH} state_t;

    localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic [1:0]    lane_q;
    logic [2:0]    funct3_q;
    logic          we_q;
    logic [29:0]   waddr_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;
    logic [1:0]    code_q;
    logic [31:0]   load_q;

    logic          access_op;
    logic          expire;
    logic          legal;
    logic          misaligned;
    logic [1:0]    fault;
    logic [3:0]    be_calc;
    logic [31:0]   wdata_calc;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic [31:0]   load_fmt;

    assign access_op = bus.mem_read | bus.mem_write;
    // An ack in the final counted cycle still completes normally.
    assign expire    = (state == ACCESS) && !bus.dmem_ack && (cnt == LAST_CNT);

    always_comb begin
        legal      = 1'b0;
        misaligned = 1'b0;
        be_calc    = 4'b1111;
        wdata_calc = bus.store_data;
        case (bus.funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !bus.mem_write;
            default:                legal = 1'b0;
        endcase
        case (bus.funct3[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << bus.addr[1:0];
                wdata_calc = {4{bus.store_data[7:0]}};
            end
            2'b01: begin
                misaligned = bus.addr[0];
                be_calc    = bus.addr[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{bus.store_data[15:0]}};
            end
            default: begin
                misaligned = (bus.addr[1:0] != 2'b00);
                be_calc    = 4'b1111;
                wdata_calc = bus.store_data;
            end
        endcase
        fault = !legal ? 2'b10 : (misaligned ? 2'b01 : 2'b00);
    end

    always_comb begin
        rbyte    = bus.dmem_rdata[{lane_q, 3'b000} +: 8];
        rhalf    = lane_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
        load_fmt = bus.dmem_rdata;
        case (funct3_q)
            3'b000:  load_fmt = {{24{rbyte[7]}}, rbyte};
            3'b100:  load_fmt = {24'h000000, rbyte};
            3'b001:  load_fmt = {{16{rhalf[15]}}, rhalf};
            3'b101:  load_fmt = {16'h0000, rhalf};
            default: load_fmt = bus.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = (access_op && fault == 2'b00) ? ACCESS : FINISH;
                end
            end
            ACCESS: begin
                if (bus.dmem_ack || expire) begin
                    state_next = FINISH;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            lane_q   <= 2'b00;
            funct3_q <= 3'b000;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            be_q     <= 4'b0000;
            wdata_q  <= '0;
            code_q   <= 2'b00;
            load_q   <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                cnt <= '0;
                if (access_op) begin
                    lane_q   <= bus.addr[1:0];
                    funct3_q <= bus.funct3;
                    we_q     <= bus.mem_write;
                    waddr_q  <= bus.addr[31:2];
                    be_q     <= be_calc;
                    wdata_q  <= wdata_calc;
                    code_q   <= fault;
                end else begin
                    code_q   <= 2'b00;
                end
            end else if (state == ACCESS) begin
                if (bus.dmem_ack) begin
                    if (!we_q) begin
                        load_q <= load_fmt;
                    end
                end else if (expire) begin
                    code_q <= 2'b11;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign bus.dmem_req   = (state == ACCESS);
    assign bus.dmem_we    = we_q;
    assign bus.dmem_addr  = {waddr_q, 2'b00};
    assign bus.dmem_be    = be_q;
    assign bus.dmem_wdata = wdata_q;
    assign bus.load_data  = load_q;
    assign bus.done       = (state == FINISH);
    assign bus.busy       = (state != IDLE);
    assign bus.err        = (state == FINISH) && (code_q != 2'b00);
    assign bus.err_code   = (state == FINISH) ? code_q : 2'b00;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a behavioural access model
module tb_load_store_unit;
    localparam int T = 16;

    typedef struct {
        bit          acc;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          err;
        logic [1:0]  code;
        logic [31:0] load;
        int          done_cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   vectors;
    int   miscompares;
    logic [31:0] lmodel;
    exp_t sb[$];

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected outcome from the access rules: size in bytes, legality, alignment, lanes.
    function automatic exp_t model(input bit rd, input bit wr, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] sd,
                                   input logic [31:0] rdw, input int delay, input int n);
        exp_t e;
        int sz;
        bit ok;
        logic [31:0] v;
        e = '{acc: 1'b0, we: 1'b0, addr: '0, be: '0, wdata: '0, err: 1'b0, code: 2'b00,
              load: lmodel, done_cyc: n + 1};
        if (!rd && !wr) return e;
        ok = wr ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        sz = 1 << f3[1:0];
        if (!ok) begin
            e.code = 2'b10;
        end else if ((a % sz) != 0) begin
            e.code = 2'b01;
        end else begin
            e.acc  = 1'b1;
            e.we   = wr;
            e.addr = a & ~32'h3;
            e.be   = 4'(((1 << sz) - 1) << (a % 4));
            for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = sd[8*(i % sz) +: 8];
            if (delay < 0 || delay >= T) begin
                e.code     = 2'b11;
                e.done_cyc = n + 1 + T;
            end else begin
                e.done_cyc = n + 2 + delay;
                if (!wr) begin
                    v = rdw >> (8 * (a % 4));
                    if (sz < 4) begin
                        v = v & ((32'd1 << (8 * sz)) - 1);
                        if (!f3[2] && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 1);
                    end
                    e.load = v;
                end
            end
        end
        e.err = (e.code != 2'b00);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.dmem_req) begin
                if (sb.size() == 0 || !sb[0].acc) begin
                    check("spurious_dmem_req", 1'b1, 1'b0);
                end else begin
                    check("dmem_fields", {bus.dmem_we, bus.dmem_addr, bus.dmem_be, bus.dmem_wdata},
                          {sb[0].we, sb[0].addr, sb[0].be, sb[0].wdata});
                end
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1'b1, 1'b0);
                end else begin
                    check("done_cycle", cyc, sb[0].done_cyc);
                    check("err_code", {bus.err, bus.err_code}, {sb[0].err, sb[0].code});
                    check("load_data", bus.load_data, sb[0].load);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic wait_empty();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check("done_seen", sb.size(), 0);
        sb.delete();
    endtask

    task automatic run(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rdw, input int delay, input bit inject);
        exp_t e;
        e = model(rd, wr, f3, a, sd, rdw, delay, cyc);
        lmodel = e.load;
        sb.push_back(e);
        bus.start = 1'b1; bus.mem_read = rd; bus.mem_write = wr;
        bus.funct3 = f3; bus.addr = a; bus.store_data = sd;
        @(negedge clk);
        if (inject) begin
            bus.start = 1'b1; bus.mem_read = 1'($urandom); bus.mem_write = 1'($urandom);
            bus.funct3 = 3'($urandom); bus.addr = $urandom; bus.store_data = $urandom;
        end else begin
            bus.start = 1'b0;
        end
        if (delay >= 0) begin
            repeat (delay) begin
                @(negedge clk);
                bus.start = 1'b0;
            end
            bus.dmem_ack = 1'b1; bus.dmem_rdata = rdw;
            @(negedge clk);
            bus.dmem_ack = 1'b0; bus.start = 1'b0;
        end else begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        wait_empty();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          rd, wr;
        int          r, d;
        logic [2:0]  f3;
        exp_t        e;
        vectors = 0; miscompares = 0; cyc = 0; lmodel = '0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.funct3 = 3'b000;
        bus.addr = '0; bus.store_data = '0; bus.dmem_rdata = '0; bus.dmem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_be, bus.dmem_wdata,
                                bus.load_data, bus.done, bus.busy, bus.err, bus.err_code}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 2, 0);
        check("lb_result", bus.load_data, 32'hFFFF_FF80);
        run(1, 0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 0, 1);
        check("lhu_result", bus.load_data, 32'h0000_BEEF);
        run(0, 1, 3'b000, 32'h0000_0011, 32'h0000_00A5, 32'h1234_5678, 1, 1);
        check("sb_keeps_load", bus.load_data, 32'h0000_BEEF);
        run(1, 0, 3'b010, 32'h0000_0006, 32'h0, 32'h0, -1, 0);
        run(1, 0, 3'b011, 32'h0000_0006, 32'h0, 32'h0, -1, 0);
        run(0, 1, 3'b100, 32'h0000_0004, 32'h55, 32'h0, -1, 0);
        run(1, 0, 3'b001, 32'h0000_0003, 32'h0, 32'h0, 0, 0);
        run(1, 1, 3'b001, 32'h0000_0042, 32'hCAFE_F00D, 32'hFFFF_FFFF, 0, 0);
        run(0, 0, 3'b111, 32'h0000_0003, 32'h0, 32'h0, -1, 1);
        run(1, 0, 3'b010, 32'h0000_0100, 32'h0, 32'h0, -1, 0);
        run(1, 0, 3'b010, 32'h0000_0104, 32'h0, 32'h0BAD_CAFE, 15, 0);
        check("ack_last_cycle", bus.load_data, 32'h0BAD_CAFE);
        run(1, 0, 3'b010, 32'h0000_0108, 32'h0, 32'h1111_2222, 16, 0);

        e = model(1, 0, 3'b010, 32'h0000_0200, 32'h0, 32'h0, -1, cyc);
        sb.push_back(e);
        bus.start = 1'b1; bus.mem_read = 1'b1; bus.mem_write = 1'b0;
        bus.funct3 = 3'b010; bus.addr = 32'h0000_0200;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_mid_access", {bus.dmem_req, bus.done, bus.busy, bus.load_data}, 0);
        sb.delete();
        lmodel = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(1, 0, 3'b010, 32'h0000_0300, 32'h0, 32'hDEAD_BEEF, 1, 0);
        check("lw_after_reset", bus.load_data, 32'hDEAD_BEEF);

        for (int k = 0; k < 250; k++) begin
            r  = $urandom_range(0, 9);
            rd = (r < 5) || (r == 8);
            wr = (r >= 5 && r < 8) || (r == 8);
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f3 = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
            d = ($urandom_range(0, 19) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 3);
            if ($urandom_range(0, 19) == 0) d = -1;
            if ($urandom_range(0, 3) == 0) begin
                bus.dmem_ack = 1'b1; bus.dmem_rdata = $urandom;
                @(negedge clk);
                bus.dmem_ack = 1'b0;
            end
            run(rd, wr, f3, $urandom & 32'h0000_FFFF, $urandom, $urandom, d, $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
